// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Each accepted operation takes one EXEC cycle, and its result is
// then held on the owner's response channel until that requester takes it.
// Optional macro ALU_ARB_FIXED_PRIO_EN: when defined, port 0 always wins ties.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [4:0]       req0_ctrl,
    input  logic [4:0]       req1_ctrl,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_param1,
    output logic [WIDTH-1:0] alu_param2,
    output logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam int unsigned CTRL_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic                owner;
    logic                pick1;
    logic                accept;
    logic                rsp_done;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [CTRL_W-1:0]   op_ctrl;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                last_grant;
`endif

    // Winner select: port 1 wins only when alone or when port 0 was granted last.
    always_comb begin
        pick1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick1 = req1_valid && !req0_valid;
`else
        pick1 = req1_valid && (!req0_valid || !last_grant);
`endif
    end

    assign req0_ready = (state == IDLE) && req0_valid && !pick1;
    assign req1_ready = (state == IDLE) && pick1;
    assign accept     = req0_ready || req1_ready;
    assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign alu_param1 = op_a;
    assign alu_param2 = op_b;
    assign alu_ctrl   = op_ctrl;

    // Arbitration FSM with operand, ownership and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= pick1 ? req1_a    : req0_a;
                        op_b    <= pick1 ? req1_b    : req0_b;
                        op_ctrl <= pick1 ? req1_ctrl : req0_ctrl;
                        owner   <= pick1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= pick1;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
